// File: rtl/nand_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : nand_arb_pkg
//  Purpose : Shared types and helpers for the NAND arbiter slice.
//            - clog2_min1 : index width that never collapses to zero bits
//            - state_t    : result-slot state (EMPTY / FULL)
//  Ports   : none (package)
//  Revision: 1.0  initial release
// ============================================================================
package nand_arb_pkg;

   // Width of an index able to address n items, at least one bit wide.
   function automatic int clog2_min1(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

   // The slot state doubles as the z_valid flag.
   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

endpackage : nand_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module  : rr_pick
//  Purpose : Combinational round-robin picker. Finds the first asserted
//            request at or after ptr_i, wrapping around.
//  Ports   : req_i  [NUM_REQ]  request vector
//            ptr_i  [ID_W]     highest-priority index this cycle
//            gnt_o  [NUM_REQ]  one-hot winner (all zero when no request)
//            k_o    [ID_W]     index of the winner
//            any_o             at least one request is asserted
//  Revision: 1.0  initial release
// ============================================================================
module rr_pick
   import nand_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = clog2_min1(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]    k_o,
   output logic               any_o
);

   logic [NUM_REQ-1:0]   mask;
   logic [2*NUM_REQ-1:0] dbl;
   logic                 found;

   // Lower half holds only requests at or above ptr; the upper half holds
   // the full vector, so a plain LSB-first search yields the wrapped order.
   always_comb begin
      mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         mask[i] = (i >= int'(ptr_i));
      end
      dbl   = {req_i, req_i & mask};
      found = 1'b0;
      k_o   = '0;
      for (int j = 0; j < 2*NUM_REQ; j++) begin
         if (!found && dbl[j]) begin
            found = 1'b1;
            k_o   = (j >= NUM_REQ) ? ID_W'(j - NUM_REQ) : ID_W'(j);
         end
      end
      any_o = |req_i;
      gnt_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         gnt_o[i] = any_o && (k_o == ID_W'(i));
      end
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/nand_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : nand_arbiter
//  Purpose : Time-shares one WIDTH-bit NAND unit between NUM_REQ requesters
//            with round-robin arbitration; the registered result is tagged
//            with the requester index and offered on a valid/ready handshake.
//  Ports   : clk, rst               clock, synchronous active-high reset
//            req     [NUM_REQ]      pending requests
//            x_in,y_in [NUM_REQ*W]  operands, requester i at [i*WIDTH +: WIDTH]
//            gnt     [NUM_REQ]      one-hot, operands captured this cycle
//            z       [WIDTH]        ~(x & y) of the granted requester
//            z_id    [ID_W]         index that produced z
//            z_valid                result slot full
//            z_ready                consumer takes z this cycle
//  Revision: 1.0  initial release
// ============================================================================
module nand_arbiter
   import nand_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int WIDTH   = 1,
   localparam int ID_W    = clog2_min1(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*WIDTH-1:0]   x_in,
   input  logic [NUM_REQ*WIDTH-1:0]   y_in,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [WIDTH-1:0]           z,
   output logic [ID_W-1:0]            z_id,
   output logic                       z_valid,
   input  logic                       z_ready
);

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  z_q, z_d;
   logic [ID_W-1:0]   z_id_q, z_id_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [ID_W-1:0]    pick_k;
   logic               pick_any;
   logic               free;
   logic               grant_en;
   logic [WIDTH-1:0]   x_sel, y_sel;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .k_o   (pick_k),
      .any_o (pick_any)
   );

   // The slot can take a new result if empty or if it drains this cycle.
   assign free     = (state_q == ST_EMPTY) | z_ready;
   assign grant_en = free & pick_any & ~rst;
   assign gnt      = grant_en ? pick_gnt : '0;

   assign x_sel = x_in[int'(pick_k)*WIDTH +: WIDTH];
   assign y_sel = y_in[int'(pick_k)*WIDTH +: WIDTH];

   always_comb begin
      state_d = state_q;
      z_d     = z_q;
      z_id_d  = z_id_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_EMPTY: if (grant_en) state_d = ST_FULL;
         ST_FULL: begin
            if (grant_en)     state_d = ST_FULL;
            else if (z_ready) state_d = ST_EMPTY;
         end
         default:             state_d = ST_EMPTY;
      endcase
      if (grant_en) begin
         z_d    = ~(x_sel & y_sel);
         z_id_d = pick_k;
         ptr_d  = (pick_k == ID_W'(NUM_REQ-1)) ? '0 : pick_k + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         z_q     <= '0;
         z_id_q  <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         z_q     <= z_d;
         z_id_q  <= z_id_d;
         ptr_q   <= ptr_d;
      end
   end

   assign z       = z_q;
   assign z_id    = z_id_q;
   assign z_valid = (state_q == ST_FULL);

endmodule : nand_arbiter
`default_nettype wire
